mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency unified memory between the fetch port (read-only) and the
//  load/store port (read/write), replacing separate instr/data memories. One transaction in flight;
//  round-robin on contention. Sits between fetch/LSU and the memory macro; stalls = !gnt.
// PARAMETERS
//  AW       32  address width (bytes)
//  DW       32  data width; BEW = DW/8 byte strobes
//  MEM_LAT  1   memory read latency in cycles, >=1 (mem_rdata valid MEM_LAT cycles after mem_en)
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst_n      in   1    reset, asynchronous, active-low
//  if_req     in   1    fetch request; hold with if_addr stable until if_gnt
//  if_addr    in   AW   fetch address
//  if_gnt     out  1    fetch accepted this cycle
//  if_rvalid  out  1    one-cycle pulse: if_rdata valid
//  if_rdata   out  DW   fetched word (held until next response)
//  d_req      in   1    load/store request; hold with d_* stable until d_gnt
//  d_we       in   1    1=store, 0=load
//  d_be       in   BEW  store byte strobes
//  d_addr     in   AW   data address
//  d_wdata    in   DW   store data
//  d_gnt      out  1    data request accepted this cycle
//  d_rvalid   out  1    one-cycle pulse: load data valid / store complete
//  d_rdata    out  DW   load data (0 for stores), held until next response
//  mem_en     out  1    memory access strobe (one cycle per transaction)
//  mem_we     out  1    memory write enable
//  mem_be     out  BEW  memory byte strobes
//  mem_addr   out  AW   memory address
//  mem_wdata  out  DW   memory write data
//  mem_rdata  in   DW   memory read data
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, last_win=DATA (fetch wins first contention), all outputs 0, rdata regs 0.
//  - States: IDLE -> WAIT -> RESP -> IDLE.
//  - IDLE: no req: stay. Exactly one req: grant it. Both: grant the side != last_win.
//    Grant cycle T: gnt=1 (combinational from state/req/last_win), mem_en=1, mem_* driven from winner
//    (fetch: mem_we=0, mem_be=all 1s); latch owner, owner_we; last_win<=owner; cnt<=MEM_LAT-1; ->WAIT.
//  - WAIT: mem_en=0; when cnt==0 capture mem_rdata into owner's rdata reg (0 if store) -> RESP; else cnt--.
//    mem_rdata sampled exactly at edge ending cycle T+MEM_LAT.
//  - RESP: owner's rvalid=1 for one cycle (cycle T+MEM_LAT+1); -> IDLE. No grant in WAIT/RESP.
//  - Throughput: one transaction per MEM_LAT+2 cycles; gnt never asserted for both ports at once.
//  - gnt only asserted when matching req=1 in IDLE; req dropped before gnt = request withdrawn, no effect.
//  - req still high in cycle after rvalid (IDLE) = new transaction, arbitrated normally.
//  - Non-owner rdata/rvalid unaffected by the other port's transactions.
//  - rst_n low mid-transaction: immediate return to reset values; in-flight response discarded, no rvalid.
//  - Stores with d_be=0 still issue a mem_en cycle and ack via d_rvalid; alignment not checked.
//  - cnt width $clog2(MEM_LAT+1); no wrap (loaded only in IDLE).
// TESTING
//  1 Reset: rst_n=0 mid-WAIT -> all outputs 0 asynchronously, no rvalid after release, busy=0.
//  2 Fetch only, MEM_LAT=1: if_req, if_addr=0x0000_0010 at T -> if_gnt@T, mem_en@T addr 0x10,
//    mem_rdata=0x00A0_0093 @T+1 -> if_rvalid@T+2, if_rdata=0x00A0_0093.
//  3 Store then load: d_we=1 addr 0x100 be=4'b1111 wdata 0xDEADBEEF -> mem_we=1, d_rvalid, d_rdata=0;
//    load 0x100 -> d_rdata=0xDEADBEEF.
//  4 Contention after reset: if_req=d_req=1 held -> grants fetch, data, fetch, data (alternating),
//    each grant MEM_LAT+2 cycles apart, never both gnt.
//  5 MEM_LAT=3: rvalid exactly 4 cycles after gnt; mem_rdata changes at T+1..T+2 ignored.
//  6 Withdrawal: d_req pulsed 1 cycle during fetch WAIT -> no d_gnt, no memory write, busy returns 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch / load-store arbiter in front of one fixed-latency unified memory
// One transaction in flight at a time; round-robin on contention, fetch wins the first tie after reset.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int BEW = DW / 8;
  localparam int CW  = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Port encoding for owner/last_win: 0 = fetch, 1 = data.
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            owner_q;
  logic            owner_we_q;
  logic            last_win_q;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   d_rdata_q;

  logic            pick_d;
  logic            grant;
  logic            capture;

  // Grant is gated with rst_n so every output reads 0 while reset is held.
  assign pick_d  = (if_req && d_req) ? ~last_win_q : d_req;
  assign grant   = rst_n && (state_q == IDLE) && (if_req || d_req);
  assign capture = (state_q == WAIT) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = WAIT;
          cnt_d   = CW'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      owner_we_q <= 1'b0;
      last_win_q <= 1'b1;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        owner_q    <= pick_d;
        owner_we_q <= pick_d & d_we;
        last_win_q <= pick_d;
      end
      if (capture) begin
        if (owner_q) d_rdata_q  <= owner_we_q ? '0 : mem_rdata;
        else         if_rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant) begin
      mem_en = 1'b1;
      if (pick_d) begin
        d_gnt     = 1'b1;
        mem_we    = d_we;
        mem_be    = d_be;
        mem_addr  = d_addr;
        mem_wdata = d_we ? d_wdata : '0;
      end else begin
        if_gnt   = 1'b1;
        mem_be   = {BEW{1'b1}};
        mem_addr = if_addr;
      end
    end
  end

  assign if_rvalid = (state_q == RESP) && !owner_q;
  assign d_rvalid  = (state_q == RESP) &&  owner_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (MEM_LAT=1 and MEM_LAT=3 instances)
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // MEM_LAT=1 instance
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // MEM_LAT=3 instance
  logic        l3_if_req, l3_if_gnt, l3_if_rvalid;
  logic [31:0] l3_if_addr, l3_if_rdata;
  logic        l3_d_gnt, l3_d_rvalid;
  logic [31:0] l3_d_rdata;
  logic        l3_mem_en, l3_mem_we, l3_busy;
  logic [3:0]  l3_mem_be;
  logic [31:0] l3_mem_addr, l3_mem_wdata, l3_mem_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] if_exp[$];
  logic [31:0] d_exp[$];

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_gnt(l3_if_gnt), .if_rvalid(l3_if_rvalid),
    .if_rdata(l3_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_gnt(l3_d_gnt), .d_rvalid(l3_d_rvalid), .d_rdata(l3_d_rdata),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_be(l3_mem_be), .mem_addr(l3_mem_addr),
    .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata), .busy(l3_busy)
  );

  // Latency-1 memory model with byte strobes; word 4 (addr 0x10) preloaded
  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe;
  bit          preloaded;
  int          wr_cnt;
  int          en_cnt;
  assign mem_rdata = rd_pipe;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 4) ? 32'h00A0_0093 : 32'h0;
      rd_pipe   <= 32'h0;
      preloaded <= 1'b1;
    end else if (mem_en) begin
      en_cnt  <= en_cnt + 1;
      rd_pipe <= mem[mem_addr[9:2]];
      if (mem_we) begin
        wr_cnt <= wr_cnt + 1;
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Scoreboard: pop expected data on each response pulse
  always @(negedge clk) begin
    if (if_rvalid) begin
      checks++;
      if (if_exp.size() == 0) begin
        errors++; $display("FAIL sb_if_unexpected: got if_rvalid with rdata %h, none expected", if_rdata);
      end else begin
        logic [31:0] e;
        e = if_exp.pop_front();
        if (if_rdata !== e) begin
          errors++; $display("FAIL sb_if_rdata: got %h expected %h", if_rdata, e);
        end
      end
    end
    if (d_rvalid) begin
      checks++;
      if (d_exp.size() == 0) begin
        errors++; $display("FAIL sb_d_unexpected: got d_rvalid with rdata %h, none expected", d_rdata);
      end else begin
        logic [31:0] e;
        e = d_exp.pop_front();
        if (d_rdata !== e) begin
          errors++; $display("FAIL sb_d_rdata: got %h expected %h", d_rdata, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (if_gnt || d_gnt) begin
      checks++;
      if (if_gnt && d_gnt) begin
        errors++; $display("FAIL dual_gnt: got if_gnt=1 d_gnt=1 expected at most one");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_gnt(input bit side, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      #1;
      if (side ? d_gnt : if_gnt) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    @(negedge clk);
    checks++;
    if ({busy, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we} !== 7'b0 || if_rdata !== 0 || d_rdata !== 0) begin
      errors++; $display("FAIL reset_state: got busy=%b mem_en=%b if_rdata=%h d_rdata=%h expected all 0",
                         busy, mem_en, if_rdata, d_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    wait_gnt(1'b0, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_gnt: got no if_gnt expected grant"); end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy_wait: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, if_rvalid, mem_en, if_gnt} !== 4'b0 || if_rdata !== 0) begin
      errors++; $display("FAIL reset_async: got busy=%b if_rvalid=%b mem_en=%b if_rdata=%h expected 0",
                         busy, if_rvalid, mem_en, if_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (if_rvalid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_discard: got if_rvalid=%b busy=%b expected 0 0", if_rvalid, busy);
      end
    end
  endtask

  task automatic test_fetch();
    bit ok;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0010;
    wait_gnt(1'b0, 10, ok);
    checks++;
    if (!ok || mem_en !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || mem_be !== 4'hF || d_gnt !== 1'b0) begin
      errors++; $display("FAIL fetch_issue: got ok=%b mem_en=%b addr=%h we=%b be=%h expected 1 1 00000010 0 f",
                         ok, mem_en, mem_addr, mem_we, mem_be);
    end
    if_exp.push_back(32'h00A0_0093);
    @(negedge clk);
    if_req = 1'b0;
    checks++;
    if (if_rvalid !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL fetch_t1: got if_rvalid=%b mem_en=%b expected 0 0", if_rvalid, mem_en);
    end
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h00A0_0093) begin
      errors++; $display("FAIL fetch_t2: got if_rvalid=%b if_rdata=%h expected 1 00a00093", if_rvalid, if_rdata);
    end
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b0 || busy !== 1'b0 || if_rdata !== 32'h00A0_0093) begin
      errors++; $display("FAIL fetch_t3: got if_rvalid=%b busy=%b if_rdata=%h expected 0 0 00a00093",
                         if_rvalid, busy, if_rdata);
    end
  endtask

  task automatic test_store_load();
    bit ok;
    bit seen;
    logic [31:0] vals [2];
    vals[0] = 32'h0;
    vals[1] = 32'hDEAD_BEEF;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      d_req = 1'b1; d_we = (n == 0); d_be = 4'hF; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
      wait_gnt(1'b1, 10, ok);
      checks++;
      if (!ok || mem_we !== (n == 0) || mem_addr !== 32'h100 || mem_be !== 4'hF ||
          (n == 0 && mem_wdata !== 32'hDEAD_BEEF)) begin
        errors++; $display("FAIL sl_issue%0d: got ok=%b we=%b addr=%h wdata=%h expected we=%0d addr 00000100",
                           n, ok, mem_we, mem_addr, mem_wdata, (n == 0));
      end
      d_exp.push_back(vals[n]);
      @(negedge clk);
      d_req = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        if (d_rvalid) seen = 1'b1;
        else @(negedge clk);
      end
      checks++;
      if (!seen || d_rdata !== vals[n]) begin
        errors++; $display("FAIL sl_resp%0d: got seen=%b d_rdata=%h expected 1 %h", n, seen, d_rdata, vals[n]);
      end
    end
    checks++;
    if (if_rdata !== 32'h00A0_0093) begin
      errors++; $display("FAIL sl_nonowner: got if_rdata=%h expected 00a00093", if_rdata);
    end
  endtask

  task automatic test_contention();
    bit ok;
    int n = 0;
    bit side [4];
    int at [4];
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (if_gnt || d_gnt) begin
        side[n] = d_gnt;
        at[n] = c;
        if (d_gnt) d_exp.push_back(32'hDEAD_BEEF);
        else       if_exp.push_back(32'h00A0_0093);
        n++;
      end
      @(negedge clk);
    end
    if_req = 1'b0; d_req = 1'b0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL cont_count: got %0d grants expected 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (side[i] !== i[0] || (i > 0 && at[i] - at[i-1] != 3)) begin
          errors++; $display("FAIL cont_grant%0d: got side=%0d gap=%0d expected side=%0d gap=3",
                             i, side[i], (i > 0) ? at[i] - at[i-1] : 3, i[0]);
        end
      end
    end
    wait_idle(10, ok);
    @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL cont_idle: got busy=1 expected 0"); end
  endtask

  task automatic test_withdraw();
    bit ok;
    int wr0, en0;
    @(negedge clk);
    wr0 = wr_cnt; en0 = en_cnt;
    if_req = 1'b1; if_addr = 32'h10;
    wait_gnt(1'b0, 10, ok);
    if_exp.push_back(32'h00A0_0093);
    @(negedge clk);
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h200; d_wdata = 32'h1234_5678;
    #1;
    checks++;
    if (d_gnt !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL wd_wait: got d_gnt=%b mem_en=%b expected 0 0", d_gnt, mem_en);
    end
    @(negedge clk);
    d_req = 1'b0;
    wait_idle(10, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || busy !== 1'b0 || wr_cnt != wr0 || en_cnt != en0 + 1) begin
      errors++; $display("FAIL wd_effect: got idle=%b writes=%0d accesses=%0d expected 1 0 1",
                         ok, wr_cnt - wr0, en_cnt - en0);
    end
  endtask

  task automatic test_lat3();
    bit ok = 1'b0;
    logic [31:0] l3_exp[$];
    logic [31:0] e;
    @(negedge clk);
    l3_if_req = 1'b1; l3_if_addr = 32'h20;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (l3_if_gnt) ok = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!ok || l3_mem_en !== 1'b1 || l3_mem_addr !== 32'h20) begin
      errors++; $display("FAIL l3_issue: got ok=%b mem_en=%b addr=%h expected 1 1 00000020", ok, l3_mem_en, l3_mem_addr);
    end
    l3_exp.push_back(32'hCAFE_0003);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      l3_if_req = 1'b0;
      case (k)
        1: l3_mem_rdata = 32'hBAD0_0001;
        2: l3_mem_rdata = 32'hBAD0_0002;
        3: l3_mem_rdata = 32'hCAFE_0003;
        default: l3_mem_rdata = 32'hBAD0_0004;
      endcase
      checks++;
      if (l3_if_rvalid !== (k == 4) || l3_mem_en !== 1'b0) begin
        errors++; $display("FAIL l3_rvalid_t%0d: got rvalid=%b mem_en=%b expected %0d 0", k, l3_if_rvalid, l3_mem_en, (k == 4));
      end
      if (k == 4) begin
        e = l3_exp.pop_front();
        checks++;
        if (l3_if_rdata !== e) begin
          errors++; $display("FAIL l3_rdata: got %h expected %h", l3_if_rdata, e);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    l3_if_req = 1'b0; l3_if_addr = '0; l3_mem_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_fetch();
    test_store_load();
    test_contention();
    test_withdraw();
    test_lat3();
    repeat (3) @(negedge clk);
    checks++;
    if (if_exp.size() != 0 || d_exp.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d/%0d pending responses expected 0/0", if_exp.size(), d_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
